ddr3_app_resp_model: RTL and testbench

- Synthesizable responder for the MIG 7-series native app interface. It is the memory-controller end that the DDR3 arbiter drives.
- Accepts app_en/app_cmd/app_addr commands and app_wdf_* write data, stores data in an on-chip RAM, and returns read data on app_rd_data with fixed latency.
- Replaces mig_7series_0 in arbiter-level simulation and in board bring-up builds without DDR3 devices.

---
 rtl/ddr3_app_resp_model.sv | 188 ++++++++++++++++++
 tb/tb_ddr3_app_resp_model.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_app_resp_model.sv
// Purpose: stand-in for the MIG 7-series native app interface, backed by on-chip RAM.
// Latency: read data returns RD_LATENCY cycles after the edge that accepts the read; writes commit one cycle after both halves are queued.
// Backpressure: app_rdy is low during calibration, on the injected gap cycle, and while any write command is still queued; app_wdf_rdy is low when the data FIFO is full.
module ddr3_app_resp_model #(
  parameter int DATA_WIDTH   = 128,
  parameter int ADDR_WIDTH   = 28,
  parameter int MEM_AW       = 10,
  parameter int RD_LATENCY   = 8,
  parameter int CALIB_CYCLES = 64,
  parameter int RDY_GAP      = 0,
  parameter int Q_DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    init_calib_complete,
  input  logic                    app_en,
  input  logic [2:0]              app_cmd,
  input  logic [ADDR_WIDTH-1:0]   app_addr,
  output logic                    app_rdy,
  input  logic                    app_wdf_wren,
  input  logic                    app_wdf_end,
  input  logic [DATA_WIDTH-1:0]   app_wdf_data,
  input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  output logic                    app_wdf_rdy,
  output logic [DATA_WIDTH-1:0]   app_rd_data,
  output logic                    app_rd_data_valid,
  output logic                    app_rd_data_end,
  output logic                    err_flag
);

  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int QAW    = $clog2(Q_DEPTH);
  localparam int CAL_W  = $clog2(CALIB_CYCLES + 1);
  localparam int GAP_W  = 16;
  localparam int DEPTH  = 1 << MEM_AW;

  localparam logic [2:0]       CMD_WR   = 3'b000;
  localparam logic [2:0]       CMD_RD   = 3'b001;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((RDY_GAP > 0) ? RDY_GAP - 1 : 0);

  typedef logic [MEM_AW-1:0] word_idx_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] dat;
    logic [MASK_W-1:0]     mask;
  } wdf_ent_t;

  // Calibration and backpressure injection state
  logic             calib;
  logic [CAL_W-1:0] cal_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_cycle;

  // Write-command queue: holds only the word index of each pending write
  word_idx_t    wq_mem [Q_DEPTH];
  logic [QAW:0] wq_wptr;
  logic [QAW:0] wq_rptr;
  logic         wq_empty;
  logic         wq_full;
  word_idx_t    wq_head;

  // Write-data FIFO
  wdf_ent_t     wdf_mem [Q_DEPTH];
  logic [QAW:0] wdf_wptr;
  logic [QAW:0] wdf_rptr;
  logic         wdf_empty;
  logic         wdf_full;
  wdf_ent_t     wdf_head;

  // Backing store and read pipeline
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [RD_LATENCY:0]   pipe_vld;
  logic [DATA_WIDTH-1:0] pipe_dat [RD_LATENCY+1];

  // Handshake decode
  word_idx_t cmd_idx;
  logic      cmd_acc;
  logic      wr_acc;
  logic      rd_acc;
  logic      bad_acc;
  logic      wdf_acc;
  logic      commit;
  logic      unused_addr;

  assign cmd_idx     = app_addr[MEM_AW+2:3];
  assign unused_addr = ^{app_addr[ADDR_WIDTH-1:MEM_AW+3], app_addr[2:0]};

  assign wq_empty  = (wq_wptr == wq_rptr);
  assign wq_full   = (wq_wptr[QAW] != wq_rptr[QAW]) &&
                     (wq_wptr[QAW-1:0] == wq_rptr[QAW-1:0]);
  assign wdf_empty = (wdf_wptr == wdf_rptr);
  assign wdf_full  = (wdf_wptr[QAW] != wdf_rptr[QAW]) &&
                     (wdf_wptr[QAW-1:0] == wdf_rptr[QAW-1:0]);
  assign wq_head   = wq_mem[wq_rptr[QAW-1:0]];
  assign wdf_head  = wdf_mem[wdf_rptr[QAW-1:0]];

  assign gap_cycle = (RDY_GAP != 0) && calib && (gap_cnt == GAP_LAST);

  // app_rdy only looks at registered state. A read must never overtake a
  // queued write, and since app_cmd is not consulted, any queued write
  // holds off every command until it has committed.
  assign app_rdy     = calib & ~wq_full & ~gap_cycle & wq_empty;
  assign app_wdf_rdy = calib & ~wdf_full;

  assign cmd_acc = app_en & app_rdy;
  assign wr_acc  = cmd_acc & (app_cmd == CMD_WR);
  assign rd_acc  = cmd_acc & (app_cmd == CMD_RD);
  assign bad_acc = cmd_acc & (app_cmd != CMD_WR) & (app_cmd != CMD_RD);
  assign wdf_acc = app_wdf_wren & app_wdf_rdy;
  assign commit  = ~wq_empty & ~wdf_empty;

  assign init_calib_complete = calib;
  assign app_rd_data         = pipe_dat[RD_LATENCY];
  assign app_rd_data_valid   = pipe_vld[RD_LATENCY];
  assign app_rd_data_end     = pipe_vld[RD_LATENCY];

  // Calibration timer: calib rises on the CALIB_CYCLES-th edge after reset and latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cal_cnt <= '0;
      calib   <= 1'b0;
    end else if (!calib) begin
      if (cal_cnt == CAL_W'(CALIB_CYCLES - 1)) calib <= 1'b1;
      else                                     cal_cnt <= cal_cnt + CAL_W'(1);
    end
  end

  // Free-running gap counter, started by calib; the last count is the gap cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
    end else if (calib && (RDY_GAP != 0)) begin
      gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + GAP_W'(1);
    end
  end

  // Queue pointers; pairing is purely positional (Nth command with Nth beat)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wq_wptr  <= '0;
      wq_rptr  <= '0;
      wdf_wptr <= '0;
      wdf_rptr <= '0;
    end else begin
      if (wr_acc)  wq_wptr  <= wq_wptr + (QAW+1)'(1);
      if (commit)  wq_rptr  <= wq_rptr + (QAW+1)'(1);
      if (wdf_acc) wdf_wptr <= wdf_wptr + (QAW+1)'(1);
      if (commit)  wdf_rptr <= wdf_rptr + (QAW+1)'(1);
    end
  end

  // Queue storage; contents are don't-care while the matching pointers say empty
  always_ff @(posedge clk) begin
    if (wr_acc)  wq_mem[wq_wptr[QAW-1:0]]   <= cmd_idx;
    if (wdf_acc) wdf_mem[wdf_wptr[QAW-1:0]] <= '{dat: app_wdf_data, mask: app_wdf_mask};
  end

  // Commit one paired write per cycle; a set mask bit leaves that byte untouched
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!wdf_head.mask[b]) mem[wq_head][b*8 +: 8] <= wdf_head.dat[b*8 +: 8];
      end
    end
  end

  // Read pipeline: stage 0 samples the RAM on the accepting edge, the rest only delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int s = 0; s <= RD_LATENCY; s++) pipe_dat[s] <= '0;
    end else begin
      pipe_vld    <= {pipe_vld[RD_LATENCY-1:0], rd_acc};
      pipe_dat[0] <= rd_acc ? mem[cmd_idx] : '0;
      for (int s = 1; s <= RD_LATENCY; s++) pipe_dat[s] <= pipe_dat[s-1];
    end
  end

  // Sticky protocol error: beat without wdf_end, or an unknown command accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag <= 1'b0;
    end else if (bad_acc || (wdf_acc && !app_wdf_end)) begin
      err_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr3_app_resp_model.sv
// Bench for ddr3_app_resp_model: directed stimulus, scoreboard of expected read beats.
// A negedge monitor pops the scoreboard on every read beat and checks data and latency.
// A second instance with RDY_GAP=4 checks backpressure injection and command conservation.
module tb_ddr3_app_resp_model;

  localparam int DW    = 128;
  localparam int AW    = 28;
  localparam int RDLAT = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_calib_complete;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic          app_rdy;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic [DW-1:0] app_wdf_data;
  logic [15:0]   app_wdf_mask;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rd_data_end;
  logic          err_flag;

  logic          g_init;
  logic          g_app_en;
  logic [2:0]    g_app_cmd;
  logic [AW-1:0] g_app_addr;
  logic          g_app_rdy;
  logic          g_wdf_wren;
  logic          g_wdf_end;
  logic [DW-1:0] g_wdf_data;
  logic [15:0]   g_wdf_mask;
  logic          g_wdf_rdy;
  logic [DW-1:0] g_rd_data;
  logic          g_rd_vld;
  logic          g_rd_end;
  logic          g_err;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int stray  = 0;
  int g_acc  = 0;
  int g_beats = 0;

  logic [DW-1:0] exp_dat[$];
  int            exp_edge[$];

  localparam logic [DW-1:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [DW-1:0] D2 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [DW-1:0] D3 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [DW-1:0] D4 = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
  localparam logic [DW-1:0] D5 = 128'h5A5A5A5A_0F0F0F0F_F0F0F0F0_A5A5A5A5;
  localparam logic [DW-1:0] DS = 128'hBADBADBA_DBADBADB_ADBADBAD_BADBADBA;

  ddr3_app_resp_model #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_AW(10), .RD_LATENCY(RDLAT),
    .CALIB_CYCLES(64), .RDY_GAP(0), .Q_DEPTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
    .err_flag(err_flag)
  );

  ddr3_app_resp_model #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_AW(10), .RD_LATENCY(RDLAT),
    .CALIB_CYCLES(64), .RDY_GAP(4), .Q_DEPTH(16)
  ) dut_gap (
    .clk(clk), .rst_n(rst_n), .init_calib_complete(g_init),
    .app_en(g_app_en), .app_cmd(g_app_cmd), .app_addr(g_app_addr), .app_rdy(g_app_rdy),
    .app_wdf_wren(g_wdf_wren), .app_wdf_end(g_wdf_end), .app_wdf_data(g_wdf_data),
    .app_wdf_mask(g_wdf_mask), .app_wdf_rdy(g_wdf_rdy), .app_rd_data(g_rd_data),
    .app_rd_data_valid(g_rd_vld), .app_rd_data_end(g_rd_end), .err_flag(g_err)
  );

  always #5 clk = ~clk;

  // Edge counter used to timestamp command acceptance
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: handshake not seen within 200 cycles, required it (cycle %0d)", name, cyc);
  endtask

  // Scoreboard monitor: every read beat must match the oldest expected entry
  always @(negedge clk) begin
    if (app_rd_data_valid) begin
      if (exp_dat.size() == 0) begin
        stray++;
        n_vec++;
        n_miss++;
        $display("FAIL stray_rd_beat: got beat %0h, required no beat (cycle %0d)", app_rd_data, cyc);
      end else begin
        logic [DW-1:0] d;
        int            e;
        d = exp_dat.pop_front();
        e = exp_edge.pop_front();
        chk("rd_data", app_rd_data, d);
        chk("rd_latency", DW'(cyc - e), DW'(RDLAT));
        chk("rd_data_end", app_rd_data_end, 1'b1);
      end
    end
    if (g_app_en && g_app_rdy) g_acc++;
    if (g_rd_vld) g_beats++;
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic issue(input logic [2:0] cmd, input logic [AW-1:0] addr, output int acc_edge);
    bit ok = 1'b0;
    acc_edge = -1;
    app_en = 1'b1; app_cmd = cmd; app_addr = addr;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (app_rdy) begin ok = 1'b1; acc_edge = cyc + 1; end
      @(posedge clk); #1;
    end
    app_en = 1'b0;
    if (!ok) timeout("cmd_accept");
  endtask

  task automatic send_wdf(input logic [DW-1:0] d, input logic [15:0] m);
    bit ok = 1'b0;
    app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = d; app_wdf_mask = m;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (app_wdf_rdy) ok = 1'b1;
      @(posedge clk); #1;
    end
    app_wdf_wren = 1'b0;
    if (!ok) timeout("wdf_accept");
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic [15:0] m);
    int e;
    send_wdf(d, m);
    issue(3'b000, addr, e);
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic [DW-1:0] d, output int e);
    issue(3'b001, addr, e);
    if (e >= 0) begin
      exp_dat.push_back(d);
      exp_edge.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_dat.size() != 0; i++) @(posedge clk);
    #1;
    chk("scoreboard_drained", DW'(exp_dat.size()), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 ns, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e_first, e_last;
    rst_n = 1'b0;
    app_en = 1'b0; app_cmd = '0; app_addr = '0;
    app_wdf_wren = 1'b0; app_wdf_end = 1'b0; app_wdf_data = '0; app_wdf_mask = '0;
    g_app_en = 1'b0; g_app_cmd = '0; g_app_addr = '0;
    g_wdf_wren = 1'b0; g_wdf_end = 1'b0; g_wdf_data = '0; g_wdf_mask = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_calib", init_calib_complete, 1'b0);
    chk("rst_app_rdy", app_rdy, 1'b0);
    chk("rst_wdf_rdy", app_wdf_rdy, 1'b0);
    chk("rst_rd_valid", app_rd_data_valid, 1'b0);
    chk("rst_rd_data", app_rd_data, '0);
    chk("rst_err", err_flag, 1'b0);

    // Calibration: high after exactly 64 edges
    @(negedge clk);
    rst_n = 1'b1;
    repeat (63) @(posedge clk);
    #1;
    chk("calib_edge63", init_calib_complete, 1'b0);
    chk("rdy_edge63", app_rdy, 1'b0);
    chk("wdf_rdy_edge63", app_wdf_rdy, 1'b0);
    @(posedge clk); #1;
    chk("calib_edge64", init_calib_complete, 1'b1);
    chk("rdy_edge64", app_rdy, 1'b1);
    chk("wdf_rdy_edge64", app_wdf_rdy, 1'b1);
    chk("idle_rd_valid", app_rd_data_valid, 1'b0);
    chk("idle_err", err_flag, 1'b0);

    // RDY_GAP=4: low on every 4th cycle counted from calib
    for (int k = 0; k < 12; k++) begin
      chk("gap_pattern", g_app_rdy, (k % 4) != 3);
      @(posedge clk); #1;
    end
    // Hold reads for 20 cycles: 5 gap cycles, so 15 accepted and 15 returned
    g_app_en = 1'b1; g_app_cmd = 3'b001; g_app_addr = '0;
    repeat (20) @(posedge clk);
    #1;
    g_app_en = 1'b0;
    repeat (RDLAT + 4) @(posedge clk);
    #1;
    chk("gap_acc_count", DW'(g_acc), DW'(15));
    chk("gap_no_loss", DW'(g_beats), DW'(15));

    // Basic write then read; rdy low while the write is queued
    send_wdf(D1, 16'h0000);
    issue(3'b000, 28'h10, e);
    chk("rdy_low_wr_pending", app_rdy, 1'b0);
    rd(28'h10, D1, e);

    // Data 20 cycles ahead of its command
    send_wdf(D2, 16'h0000);
    repeat (20) @(posedge clk);
    #1;
    issue(3'b000, 28'h40, e);
    rd(28'h40, D2, e);

    // Command without data stalls app_rdy until the beat arrives
    issue(3'b000, 28'h48, e);
    for (int k = 0; k < 8; k++) begin
      chk("rdy_low_no_data", app_rdy, 1'b0);
      @(posedge clk); #1;
    end
    send_wdf(D3, 16'h0000);
    rd(28'h48, D3, e);

    // Byte mask: lower 8 bytes keep 0xFF, upper 8 bytes written to 0
    wr(28'h80, {DW{1'b1}}, 16'h0000);
    wr(28'h80, '0, 16'h00FF);
    rd(28'h80, 128'h0000000000000000FFFFFFFFFFFFFFFF, e);

    // Alias: 0x2000 wraps to word 0 with 1024 words
    wr(28'h0, D4, 16'h0000);
    rd(28'h2000, D4, e);

    // 16 back-to-back reads
    for (int i = 0; i < 16; i++) wr(28'h200 + AW'(i * 8), {4{32'hA5000000 | 32'(i)}}, 16'h0000);
    e_first = 0;
    e_last = 0;
    for (int i = 0; i < 16; i++) begin
      rd(28'h200 + AW'(i * 8), {4{32'hA5000000 | 32'(i)}}, e);
      if (i == 0) e_first = e;
      e_last = e;
    end
    chk("burst_consecutive", DW'(e_last - e_first), DW'(15));
    drain();

    // Unknown command sets a sticky error
    chk("err_before", err_flag, 1'b0);
    issue(3'b111, 28'h0, e);
    chk("err_set", err_flag, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("err_sticky", err_flag, 1'b1);

    // Reset with 3 reads in flight and a stale data beat queued
    send_wdf(DS, 16'h0000);
    rd(28'h10, D1, e);
    rd(28'h10, D1, e);
    rd(28'h10, D1, e);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_dat.delete();
    exp_edge.delete();
    #1;
    chk("midrst_rd_valid", app_rd_data_valid, 1'b0);
    chk("midrst_rd_data", app_rd_data, '0);
    chk("midrst_calib", init_calib_complete, 1'b0);
    chk("midrst_err", err_flag, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("postrst_rd_valid", app_rd_data_valid, 1'b0);
    // Stale beat must be gone, so this command pairs with D5
    send_wdf(D5, 16'h0000);
    issue(3'b000, 28'h10, e);
    rd(28'h10, D5, e);
    chk("postrst_err", err_flag, 1'b0);
    drain();
    chk("stray_beats", DW'(stray), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
